// File: rtl/gpio_mulcount_pkg.sv
// Shared constants for the GPIO emulator multiply/popcount peripheral:
// FSM encoding, register offsets and STAT/CTRL bit positions.
package gpio_mulcount_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StMult   = 2'd1;
  localparam state_t StPopcnt = 2'd2;
  localparam state_t StDone   = 2'd3;

  localparam logic [15:0] OffA1   = 16'h0000;
  localparam logic [15:0] OffA2   = 16'h0008;
  localparam logic [15:0] OffW    = 16'h0010;
  localparam logic [15:0] OffL    = 16'h0018;
  localparam logic [15:0] OffCtrl = 16'h0020;
  localparam logic [15:0] OffCnt  = 16'h0028;
  localparam logic [15:0] OffGin  = 16'h0030;
  localparam logic [15:0] WinSize = 16'h0040;

  localparam int unsigned StatValid = 0;
  localparam int unsigned StatReady = 1;
  localparam int unsigned StatBusy  = 2;
  localparam int unsigned StatErr   = 3;

  localparam int unsigned CtrlStart  = 0;
  localparam int unsigned CtrlClrErr = 1;

endpackage

// File: rtl/gpio_mulcount_shiftadd.sv
// Bit-serial shift-add multiplier: one multiplier bit per cycle, OP_W cycles per product.
// done_o is high during the final accumulation cycle; product_o is valid from the next cycle on.
module gpio_mulcount_shiftadd #(
  parameter int unsigned OP_W = 24
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic              done_o,
  output logic [2*OP_W-1:0] product_o
);

  localparam int unsigned PW   = 2 * OP_W;
  localparam int unsigned IdxW = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(OP_W - 1);

  logic [OP_W-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            run_q, run_d;
  logic [PW-1:0]   a_ext;

  assign a_ext = {{OP_W{1'b0}}, a_q};

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    idx_d = idx_q;
    run_d = run_q;
    if (start_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
      idx_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (b_q[idx_q]) begin
        acc_d = acc_q + (a_ext << idx_q);
      end
      idx_d = idx_q + IdxW'(1);
      if (idx_q == LastIdx) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      run_q <= run_d;
    end
  end

  assign done_o    = run_q && (idx_q == LastIdx);
  assign product_o = acc_q;

endmodule

// File: rtl/gpio_mulcount_unit.sv
// Bus-mapped multiply/popcount peripheral: register file, control FSM and popcount stage
// around the bit-serial multiplier. gpio_out mirrors the completed-operation counter.
module gpio_mulcount_unit
  import gpio_mulcount_pkg::*;
#(
  parameter int unsigned OP_W      = 24,
  parameter int unsigned RES_W     = 32,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0380
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out
);

  localparam int unsigned PW = 2 * OP_W;
  localparam int unsigned LW = $clog2(RES_W + 1);

  state_t          state_q, state_d;
  logic [OP_W-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [RES_W-1:0] w_q, w_d;
  logic [LW-1:0]   l_q, l_d, pop_q, pop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]     gin_q, gin_d, sdata_out_q, sdata_out_d;
  logic            err_q, err_d, valid_q, valid_d, valid_n_q, valid_n_d;
  logic            lat_q, rise_q;

  logic [15:0] off;
  logic        in_win, sel_a1, sel_a2, sel_ctrl;
  logic        busy, start_req, start_go, violation;
  logic        mul_done;
  logic [PW-1:0] mul_prod;
  logic [LW-1:0] pop_cnt;
  logic [31:0]   rdata;
  logic          unused_wdata;

  assign unused_wdata = ^sdata_in;

  assign off      = saddress - BASE_ADDR;
  assign in_win   = (saddress >= BASE_ADDR) && (off < WinSize);
  assign sel_a1   = in_win && (off == OffA1);
  assign sel_a2   = in_win && (off == OffA2);
  assign sel_ctrl = in_win && (off == OffCtrl);

  assign busy      = (state_q != StIdle);
  assign start_req = swr && sel_ctrl && sdata_in[CtrlStart];
  assign start_go  = start_req && !busy;
  assign violation = busy && swr && (sel_a1 || sel_a2 || start_req);

  gpio_mulcount_shiftadd #(
    .OP_W(OP_W)
  ) u_shiftadd (
    .clk      (clk),
    .n_reset  (n_reset),
    .start_i  (start_go),
    .a_i      (a1_q),
    .b_i      (a2_q),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < RES_W; i++) begin
      pop_cnt = pop_cnt + LW'(mul_prod[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    w_d       = w_q;
    l_d       = l_q;
    pop_d     = pop_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    valid_n_d = valid_n_q;
    err_d     = err_q;

    if (swr && sel_a1 && !busy) a1_d = sdata_in[OP_W-1:0];
    if (swr && sel_a2 && !busy) a2_d = sdata_in[OP_W-1:0];

    // A clear and a fresh violation in the same cycle must leave ERR set.
    if (swr && sel_ctrl && sdata_in[CtrlClrErr]) err_d = 1'b0;
    if (violation) err_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (start_go) state_d = StMult;
      end
      StMult: begin
        if (mul_done) state_d = StPopcnt;
      end
      StPopcnt: begin
        pop_d     = pop_cnt;
        valid_n_d = ((mul_prod >> RES_W) == '0);
        state_d   = StDone;
      end
      default: begin
        w_d     = mul_prod[RES_W-1:0];
        l_d     = pop_q;
        valid_d = valid_n_q;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rdata = '0;
    if (in_win) begin
      case (off)
        OffA1:   rdata = 32'(a1_q);
        OffA2:   rdata = 32'(a2_q);
        OffW:    rdata = 32'(w_q);
        OffL:    rdata = 32'(l_q);
        OffCtrl: begin
          rdata[StatValid] = valid_q;
          rdata[StatReady] = !busy;
          rdata[StatBusy]  = busy;
          rdata[StatErr]   = err_q;
        end
        OffCnt:  rdata = 32'(cnt_q);
        OffGin:  rdata = gin_q;
        default: rdata = '0;
      endcase
    end
    sdata_out_d = srd ? rdata : sdata_out_q;
    gin_d       = rise_q ? gpio_in : gin_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      a1_q        <= '0;
      a2_q        <= '0;
      w_q         <= '0;
      l_q         <= '0;
      pop_q       <= '0;
      cnt_q       <= '0;
      gin_q       <= '0;
      sdata_out_q <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b1;
      valid_n_q   <= 1'b1;
      lat_q       <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      w_q         <= w_d;
      l_q         <= l_d;
      pop_q       <= pop_d;
      cnt_q       <= cnt_d;
      gin_q       <= gin_d;
      sdata_out_q <= sdata_out_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      valid_n_q   <= valid_n_d;
      lat_q       <= gpio_latch;
      rise_q      <= gpio_latch && !lat_q;
    end
  end

  assign sdata_out = sdata_out_q;
  assign gpio_out  = 32'(cnt_q);

endmodule

// File: tb/tb_gpio_mulcount_unit.sv
// Directed plus randomized bench for gpio_mulcount_unit: a default build and a narrow
// CNT_W=4 build share one bus at different base addresses.
module tb_gpio_mulcount_unit;

  localparam logic [15:0] B0 = 16'h0380;
  localparam logic [15:0] B1 = 16'h0400;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = '0;
  logic [31:0] gpio_in = '0;
  logic        gpio_latch = 1'b0;
  logic [31:0] so0, so1, go0, go1;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_cnt [2];
  bit          exp_err [2];
  bit          exp_valid [2];

  always #5 clk = ~clk;

  gpio_mulcount_unit #(
    .OP_W(24), .RES_W(32), .CNT_W(16), .BASE_ADDR(B0)
  ) dut0 (
    .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(so0), .gpio_in(gpio_in), .gpio_latch(gpio_latch),
    .gpio_out(go0)
  );

  gpio_mulcount_unit #(
    .OP_W(4), .RES_W(6), .CNT_W(4), .BASE_ADDR(B1)
  ) dut1 (
    .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(so1), .gpio_in(gpio_in), .gpio_latch(gpio_latch),
    .gpio_out(go1)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    saddress = a; sdata_in = d; swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    saddress = a; srd = 1'b1;
    @(negedge clk);
    srd = 1'b0;
    d = (a >= B1) ? so1 : so0;
  endtask

  function automatic logic [31:0] stat(input int k, input bit bsy);
    return {28'b0, exp_err[k], bsy, !bsy, exp_valid[k]};
  endfunction

  // Writes operands, starts, waits the minimum latency and checks every result register.
  task automatic op(input int k, input logic [31:0] a, input logic [31:0] b, input string tag);
    int opw, resw;
    logic [15:0] base;
    logic [63:0] prod;
    logic [31:0] w, l, v;
    opw  = (k != 0) ? 4 : 24;
    resw = (k != 0) ? 6 : 32;
    base = (k != 0) ? B1 : B0;
    wr(base + 16'h00, a);
    wr(base + 16'h08, b);
    wr(base + 16'h20, 32'h1);
    repeat (opw + 1) @(negedge clk);
    prod = (64'(a) & ((64'd1 << opw) - 1)) * (64'(b) & ((64'd1 << opw) - 1));
    w = 32'(prod & ((64'd1 << resw) - 1));
    l = $countones(w);
    exp_valid[k] = ((prod >> resw) == 0);
    exp_cnt[k] = (exp_cnt[k] + 1) & ((k != 0) ? 32'hF : 32'hFFFF);
    rd(base + 16'h10, v); check({tag, "_w"}, v, w);
    rd(base + 16'h18, v); check({tag, "_l"}, v, l);
    rd(base + 16'h20, v); check({tag, "_stat"}, v, stat(k, 1'b0));
    rd(base + 16'h28, v); check({tag, "_cnt"}, v, exp_cnt[k]);
    check({tag, "_gpio_out"}, (k != 0) ? go1 : go0, exp_cnt[k]);
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      exp_cnt[k] = 0; exp_err[k] = 1'b0; exp_valid[k] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] v;
    reset_model();
    repeat (3) @(negedge clk);
    n_reset = 1'b1;

    // Reset state.
    check("rst_sdata_out", so0, 32'h0);
    check("rst_gpio_out", go0, 32'h0);
    rd(B0 + 16'h20, v); check("rst_stat", v, 32'h3);
    rd(B0 + 16'h10, v); check("rst_w", v, 32'h0);
    rd(B0 + 16'h28, v); check("rst_cnt", v, 32'h0);
    rd(B0 + 16'h30, v); check("rst_gin", v, 32'h0);

    // Basic product and the all-ones truncation case.
    op(0, 32'd3, 32'd5, "mul3x5");
    check("mul3x5_gpio_one", go0, 32'h1);
    op(0, 32'hFFFFFF, 32'hFFFFFF, "mulff");
    rd(B0 + 16'h10, v); check("mulff_w_const", v, 32'hFE000001);
    op(0, 32'h0, 32'h123456, "mulzero");

    // Simultaneous read and write returns the pre-write value.
    @(negedge clk);
    saddress = B0; sdata_in = 32'd9; srd = 1'b1; swr = 1'b1;
    @(negedge clk);
    srd = 1'b0; swr = 1'b0;
    check("rdwr_old", so0, 32'h0);
    rd(B0, v); check("rdwr_new", v, 32'd9);

    // Busy protection: ignored writes, sticky ERR, single count.
    wr(B0 + 16'h00, 32'd3);
    wr(B0 + 16'h08, 32'd5);
    wr(B0 + 16'h20, 32'h1);
    rd(B0 + 16'h20, v); check("busy_stat", v, stat(0, 1'b1));
    wr(B0 + 16'h00, 32'd7);
    wr(B0 + 16'h20, 32'h1);
    exp_err[0] = 1'b1;
    wr(B0 + 16'h20, 32'h3);  // clear and violation together
    rd(B0 + 16'h20, v); check("busy_err_stat", v, stat(0, 1'b1));
    repeat (30) @(negedge clk);
    exp_valid[0] = 1'b1;
    exp_cnt[0] = exp_cnt[0] + 1;
    rd(B0 + 16'h10, v); check("err_w", v, 32'd15);
    rd(B0 + 16'h20, v); check("err_stat", v, 32'hB);
    rd(B0 + 16'h28, v); check("err_cnt", v, exp_cnt[0]);
    rd(B0 + 16'h00, v); check("err_a1_kept", v, 32'd3);
    wr(B0 + 16'h20, 32'h2);
    exp_err[0] = 1'b0;
    rd(B0 + 16'h20, v); check("clr_stat", v, 32'h3);

    // Reset in the middle of MULT.
    wr(B0 + 16'h00, 32'd100);
    wr(B0 + 16'h08, 32'd200);
    wr(B0 + 16'h20, 32'h1);
    repeat (9) @(negedge clk);
    n_reset = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    check("midrst_sdata_out", so0, 32'h0);
    n_reset = 1'b1;
    rd(B0 + 16'h20, v); check("midrst_stat", v, 32'h3);
    rd(B0 + 16'h10, v); check("midrst_w", v, 32'h0);
    rd(B0 + 16'h18, v); check("midrst_l", v, 32'h0);
    rd(B0 + 16'h28, v); check("midrst_cnt", v, 32'h0);
    check("midrst_gpio_out", go0, 32'h0);
    op(0, 32'd2, 32'd2, "post_rst");

    // Randomized products on the wide build.
    for (int i = 0; i < 6; i++) begin
      op(0, $urandom, (i == 2) ? 32'h1 : $urandom, "rand0");
    end

    // Counter wrap on the CNT_W=4 build (also checks RES_W truncation there).
    for (int i = 0; i < 16; i++) begin
      op(1, $urandom_range(0, 15), $urandom_range(0, 15), "wrap");
    end
    check("wrap_gpio_zero", go1, 32'h0);
    op(1, 32'd15, 32'd15, "wrap17");
    check("wrap17_gpio_one", go1, 32'h1);

    // GPIO capture and unmapped read.
    @(negedge clk);
    gpio_in = 32'hA5A5_0F0F;
    gpio_latch = 1'b1;
    repeat (3) @(negedge clk);
    gpio_latch = 1'b0;
    gpio_in = 32'h1234_5678;
    rd(B0 + 16'h30, v); check("gin", v, 32'hA5A50F0F);
    rd(B1 + 16'h30, v); check("gin_small", v, 32'hA5A50F0F);
    rd(B0 + 16'h38, v); check("unmapped", v, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_mulcount_unit.md
Name: gpio_mulcount_unit

Overview:
Parametrised bus-mapped arithmetic peripheral for the GPIO emulator. Takes two OP_W-bit operands, computes the product with a bit-serial shift-add engine, and truncates the result to RES_W bits. It then reports the population count of the result, an overflow/valid flag and a completed-operation counter. The counter is driven on gpio_out. All bus strobes are sampled synchronously on clk. The block sits on the same saddress/srd/swr slave bus as the other emulated peripherals.

Parameters:
OP_W, 24, operand width (2..32)
RES_W, 32, result register width (must be <= 2*OP_W and <= 32)
CNT_W, 16, completed-operation counter width (<= 32)
BASE_ADDR, 16'h0380, base of the register window

Ports:
clk  in  1  clock
n_reset  in  1  reset, asynchronous, active-low
saddress  in  16  bus address
srd  in  1  read strobe, one clk cycle wide
swr  in  1  write strobe, one clk cycle wide
sdata_in  in  32  write data
sdata_out  out  32  registered read data
gpio_in  in  32  raw GPIO inputs
gpio_latch  in  1  GPIO input capture request (level, edge-detected on clk)
gpio_out  out  32  zero-extended operation counter

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 A1: RW, low OP_W bits used.
  - 0x08 A2: RW, low OP_W bits used.
  - 0x10 W: RO, result.
  - 0x18 L: RO, popcount.
  - 0x20 CTRL/STAT: write bit0=1 starts an operation; write bit1=1 clears ERR. Read returns {28'b0, ERR, BUSY, READY, VALID}.
  - 0x28 CNT: RO, operation counter.
  - 0x30 GIN: RO, latched gpio_in.
- Reset (async): A1=A2=W=L=0, CNT=0, GIN=0, sdata_out=0, ERR=0, BUSY=0, READY=1, VALID=1, FSM=IDLE.
- Reads: on an srd cycle, sdata_out updates at the next clk edge with the addressed register. Unmapped offsets return 0. sdata_out holds its value between reads.
- Writes: take effect at the clk edge of the swr cycle.
- Simultaneous srd and swr: both execute; the read returns the pre-write value.
- FSM states IDLE, MULT, POPCNT, DONE:
  - IDLE: a start write latches A1/A2 into internal copies, sets BUSY=1, READY=0, clears the bit index, and moves to MULT.
  - MULT: runs exactly OP_W cycles. Each cycle, if bit i of A2 is set, the accumulator (2*OP_W bits) adds A1<<i.
  - POPCNT: 1 cycle. Computes the popcount of acc[RES_W-1:0] and VALID_n = (acc[2*OP_W-1:RES_W] == 0).
  - DONE: 1 cycle. Loads W and L, sets VALID=VALID_n, BUSY=0, READY=1, CNT=CNT+1 (wraps modulo 2^CNT_W), then returns to IDLE.
- Latency: start written at edge t; new W/L/STAT are readable via an srd issued at or after edge t+OP_W+3.
- W and L hold their previous values while BUSY.
- L width is clog2(RES_W+1), zero-extended on read.
- Busy protection: while BUSY, writes to A1, A2 or a start are ignored and ERR is set (sticky). An ERR-clear write is always accepted. A clear and a new violation in the same cycle leave ERR=1.
- Start with A1=0 or A2=0 still runs the full OP_W cycles; the result is W=0, L=0, VALID=1.
- GIN captures gpio_in on the clk edge following a detected 0->1 transition of gpio_latch.
- gpio_out = zero-extended CNT at all times.
- Reset asserted mid-operation aborts immediately to reset values; CNT is not incremented.

Decomposition:
- Package gpio_mulcount_pkg: FSM state enum; register offset constants; STAT bit indices (VALID=0, READY=1, BUSY=2, ERR=3); CTRL bit indices (START=0, CLR_ERR=1).
- Sub-module gpio_mulcount_shiftadd: bit-serial multiplier with start/done handshake, parameters OP_W, outputs the 2*OP_W product.
- Popcount and register file remain in gpio_mulcount_unit.

Test Plan:
- A1=3, A2=5, start, wait OP_W+3 cycles -> W=15, L=4, STAT=0x3, CNT=1, gpio_out=1.
- A1=A2=0xFFFFFF (OP_W=24, RES_W=32) -> product 0xFFFFFE000001; W=0xFE000001, L=8, STAT=0x2 (VALID=0).
- Start, then write A1=7 and a second start while BUSY -> ERR=1, STAT=0xE; the original result is unaffected; CNT increments by 1 only; writing CTRL=0x2 afterwards -> STAT=0x3.
- Assert n_reset at MULT cycle 10 -> STAT=0x3, W=0, L=0, CNT=0, sdata_out=0; a fresh 2*2 after reset gives W=4, L=1.
- CNT_W=4 build: 16 back-to-back operations -> CNT=0, gpio_out=0; the 17th gives 1.
- gpio_in=0xA5A5_0F0F, pulse gpio_latch, change gpio_in, read 0x30 -> 0xA5A50F0F; read unmapped 0x38 -> 0.
